// File: rtl/paddle_motion_ctrl_if.sv
// Paddle command/plot interface: per-frame commands in, pixel stream and status out.
// The master drives commands (a command source or a bench); the slave is the paddle controller.
interface paddle_motion_ctrl_if;
    logic       frame_tick;
    logic       go;
    logic       up;
    logic       down;
    logic       speed;
    logic [6:0] y_pos;
    logic       busy;
    logic       done;
    logic       plot;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    logic       tick_overrun;

    modport master (
        output frame_tick, go, up, down, speed,
        input  y_pos, busy, done, plot, x_out, y_out, colour_out, tick_overrun
    );

    modport slave (
        input  frame_tick, go, up, down, speed,
        output y_pos, busy, done, plot, x_out, y_out, colour_out, tick_overrun
    );
endinterface

// File: rtl/paddle_motion_ctrl.sv
// Paddle motion controller: per frame tick, erases the paddle column, moves with clamping, redraws.
// Optional acceleration after a long same-direction fast run is enabled by PADDLE_ACCEL_EN.
module paddle_motion_ctrl #(
    parameter logic [7:0]  PADDLE_X = 8'd152,
    parameter int unsigned PADDLE_H = 16,
    parameter int unsigned SCREEN_H = 120,
    parameter logic [6:0]  RESET_Y  = 7'd56,
    parameter logic [2:0]  COLOUR   = 3'b111
) (
    input logic                 clock,
    input logic                 reset,
    paddle_motion_ctrl_if.slave bus
);

    localparam logic [7:0] YMAX     = 8'(SCREEN_H - PADDLE_H);
    localparam logic [4:0] CNT_LAST = 5'(PADDLE_H - 1);

    typedef enum logic [2:0] {StIdle, StErase, StMove, StDraw, StDone} state_e;

    state_e     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [6:0] y_q, y_d;
    logic       go_q, go_d;
    logic       up_q, up_d;
    logic       down_q, down_d;
    logic       speed_q, speed_d;
    logic       overrun_q;

    logic       moving;
    logic [7:0] step;
    logic [7:0] y_ext;
    logic [7:0] y_dn;
    logic [6:0] y_next;
    logic [6:0] pix_y;

    logic       plot;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    logic       busy;
    logic       done;

    assign moving = go_q && (up_q ^ down_q);
    assign y_ext  = {1'b0, y_q};
    assign pix_y  = 7'(y_q + {2'b00, cnt_q});

`ifdef PADDLE_ACCEL_EN
    logic [3:0] run_q, run_d;
    logic       dir_q;

    // Step 3 only continues an established fast run in the same direction.
    always_comb begin
        step  = speed_q ? 8'd2 : 8'd1;
        run_d = 4'd0;
        if (moving && speed_q) begin
            if (run_q != 4'd0 && dir_q == down_q) begin
                if (run_q >= 4'd8) step = 8'd3;
                run_d = (run_q == 4'd15) ? 4'd15 : run_q + 4'd1;
            end else begin
                run_d = 4'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_q <= 4'd0;
            dir_q <= 1'b0;
        end else if (state_q == StMove) begin
            run_q <= run_d;
            if (moving) dir_q <= down_q;
        end
    end
`else
    assign step = speed_q ? 8'd2 : 8'd1;
`endif

    // 8-bit arithmetic so the downward sum cannot wrap before clamping.
    assign y_dn = y_ext + step;

    always_comb begin
        y_next = y_q;
        if (moving) begin
            if (up_q) begin
                y_next = (y_ext < step) ? 7'd0 : 7'(y_ext - step);
            end else begin
                y_next = (y_dn > YMAX) ? 7'(YMAX) : 7'(y_dn);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 5'd0;
            y_q     <= RESET_Y;
            go_q    <= 1'b0;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            speed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            go_q    <= go_d;
            up_q    <= up_d;
            down_q  <= down_d;
            speed_q <= speed_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        y_d        = y_q;
        go_d       = go_q;
        up_d       = up_q;
        down_d     = down_q;
        speed_d    = speed_q;
        plot       = 1'b0;
        x_out      = 8'd0;
        y_out      = 7'd0;
        colour_out = 3'd0;
        busy       = 1'b1;
        done       = 1'b0;

        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (bus.frame_tick) begin
                    go_d    = bus.go;
                    up_d    = bus.up;
                    down_d  = bus.down;
                    speed_d = bus.speed;
                    cnt_d   = 5'd0;
                    state_d = StErase;
                end
            end
            StErase: begin
                plot  = 1'b1;
                x_out = PADDLE_X;
                y_out = pix_y;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = 5'd0;
                    state_d = StMove;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            StMove: begin
                y_d     = y_next;
                state_d = StDraw;
            end
            StDraw: begin
                plot       = 1'b1;
                x_out      = PADDLE_X;
                y_out      = pix_y;
                colour_out = COLOUR;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = 5'd0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Ticks outside IDLE are dropped but remembered until reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else if (bus.frame_tick && state_q != StIdle) begin
            overrun_q <= 1'b1;
        end
    end

    assign bus.y_pos        = y_q;
    assign bus.busy         = busy;
    assign bus.done         = done;
    assign bus.plot         = plot;
    assign bus.x_out        = x_out;
    assign bus.y_out        = y_out;
    assign bus.colour_out   = colour_out;
    assign bus.tick_overrun = overrun_q;

endmodule

// File: tb/tb_paddle_motion_ctrl.sv
// Self-checking bench for paddle_motion_ctrl: table vectors, corner sequences and random updates
// checked cycle by cycle against a behavioural model of the erase/move/draw frame update.
module tb_paddle_motion_ctrl;

    localparam int H     = 16;
    localparam int YMAX  = 104;
    localparam int PX    = 152;
    localparam int LAST  = 2 * H + 3;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    paddle_motion_ctrl_if bus ();

    paddle_motion_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int m_y      = 56;
    int m_run    = 0;
    int m_dir    = 0;
    int max_yout = 0;

    typedef struct {
        bit g;
        bit u;
        bit d;
        bit s;
        int exp_y;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference move rule: plain integer clamp into 0..YMAX.
    task automatic model_move(input bit g, input bit u, input bit d, input bit s);
        int  step;
        bit  moving;
        int  dir;
        moving = g && (u != d);
        dir    = d;
        step   = s ? 2 : 1;
`ifdef PADDLE_ACCEL_EN
        if (moving && s && m_run >= 8 && dir == m_dir) step = 3;
        if (!moving || !s) m_run = 0;
        else if (m_run > 0 && dir == m_dir) m_run = (m_run < 15) ? m_run + 1 : 15;
        else m_run = 1;
        if (moving) m_dir = dir;
`endif
        if (moving) begin
            if (u) m_y = (m_y < step) ? 0 : m_y - step;
            else   m_y = (m_y + step > YMAX) ? YMAX : m_y + step;
        end
    endtask

    function automatic int pack(input int p, input int x, input int y, input int c,
                                input int b, input int dn);
        return (p << 20) | (x << 12) | (y << 5) | (c << 2) | (b << 1) | dn;
    endfunction

    // One full update; tick_at pulses an extra (ignored) tick in that cycle, -1 for none.
    task automatic run_update(input bit g, input bit u, input bit d, input bit s,
                              input int tick_at);
        int y0, y1, exp_v, act_v;
        @(negedge clock);
        bus.frame_tick = 1'b1;
        bus.go = g; bus.up = u; bus.down = d; bus.speed = s;
        y0 = m_y;
        model_move(g, u, d, s);
        y1 = m_y;
        for (int c = 1; c <= LAST; c++) begin
            @(negedge clock);
            bus.frame_tick = (c == tick_at);
            bus.go    = 1'($urandom);
            bus.up    = 1'($urandom);
            bus.down  = 1'($urandom);
            bus.speed = 1'($urandom);
            if (c <= H)              exp_v = pack(1, PX, y0 + c - 1, 0, 1, 0);
            else if (c == H + 1)     exp_v = pack(0, 0, 0, 0, 1, 0);
            else if (c <= 2 * H + 1) exp_v = pack(1, PX, y1 + c - H - 2, 7, 1, 0);
            else if (c == 2 * H + 2) exp_v = pack(0, 0, 0, 0, 1, 1);
            else                     exp_v = pack(0, 0, 0, 0, 0, 0);
            act_v = pack(int'(bus.plot), int'(bus.x_out), int'(bus.y_out),
                         int'(bus.colour_out), int'(bus.busy), int'(bus.done));
            check($sformatf("pix_c%0d", c), act_v, exp_v);
            if (bus.plot && int'(bus.y_out) > max_yout) max_yout = int'(bus.y_out);
        end
        bus.frame_tick = 1'b0;
        check("y_pos", int'(bus.y_pos), y1);
    endtask

    initial begin
        bus.frame_tick = 1'b0;
        bus.go = 1'b0; bus.up = 1'b0; bus.down = 1'b0; bus.speed = 1'b0;
        reset = 1'b1;
        tbl[0] = '{1, 0, 1, 0, 57};
        tbl[1] = '{0, 1, 0, 1, 57};
        tbl[2] = '{1, 1, 1, 1, 57};
        tbl[3] = '{1, 1, 0, 1, 55};
        tbl[4] = '{1, 0, 0, 1, 55};
        tbl[5] = '{1, 0, 1, 1, 57};

        repeat (3) @(negedge clock);
        check("rst_y_pos", int'(bus.y_pos), 56);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_plot", int'(bus.plot), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_overrun", int'(bus.tick_overrun), 0);
        reset = 1'b0;

        // Reset in the middle of DRAW must abort with y back at its reset row.
        @(negedge clock);
        bus.frame_tick = 1'b1; bus.go = 1'b1; bus.down = 1'b1; bus.speed = 1'b1;
        @(negedge clock);
        bus.frame_tick = 1'b0;
        repeat (H + 4) @(negedge clock);
        check("mid_draw_plot", int'(bus.plot), 1);
        check("mid_draw_y_pos", int'(bus.y_pos), 58);
        reset = 1'b1;
        #1;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_plot", int'(bus.plot), 0);
        check("abort_y_pos", int'(bus.y_pos), 56);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("abort_stay_idle", int'(bus.busy), 0);

        for (int i = 0; i < 6; i++) begin
            run_update(tbl[i].g, tbl[i].u, tbl[i].d, tbl[i].s, -1);
            check($sformatf("tbl%0d_y", i), int'(bus.y_pos), tbl[i].exp_y);
        end
        check("no_overrun_yet", int'(bus.tick_overrun), 0);

        for (int i = 0; i < 56; i++) run_update(1, 1, 0, 0, -1);
        check("reach_y1", int'(bus.y_pos), 1);
        run_update(1, 1, 0, 1, -1);
        check("clamp_top", int'(bus.y_pos), 0);
        run_update(1, 1, 0, 1, -1);
        check("clamp_top_again", int'(bus.y_pos), 0);

        for (int i = 0; i < 103; i++) run_update(1, 0, 1, 0, -1);
        check("reach_y103", int'(bus.y_pos), 103);
        run_update(1, 0, 1, 1, -1);
        check("clamp_bot", int'(bus.y_pos), 104);
        run_update(1, 0, 1, 1, -1);
        check("clamp_bot_again", int'(bus.y_pos), 104);
        check("max_y_out", max_yout, 119);

        run_update(1, 1, 0, 0, 10);
        check("overrun_set", int'(bus.tick_overrun), 1);
        run_update(1, 1, 0, 0, 2 * H + 2);
        check("overrun_sticky", int'(bus.tick_overrun), 1);
        check("after_done_tick_y", int'(bus.y_pos), 102);

        for (int i = 0; i < 40; i++) begin
            run_update(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2 * H + 2)) : -1);
        end
        check("rand_final_y", int'(bus.y_pos), m_y);

`ifdef PADDLE_ACCEL_EN
        for (int i = 0; i < 120 && m_y > 0; i++) run_update(1, 1, 0, 0, -1);
        check("accel_start_y", int'(bus.y_pos), 0);
        for (int i = 0; i < 10; i++) run_update(1, 0, 1, 1, -1);
        check("accel_y", int'(bus.y_pos), 22);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
